// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse arbiter family.
// Imported by the picker and the top-level arbiter.
package pulse_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int CW_DEF    = 16;
    localparam int WIDTH_MIN = 1;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

endpackage

// File: rtl/pulse_rr_pick.sv
// Combinational round-robin picker: searches last+1, last+2, ...
// modulo N_REQ and returns the first set bit of the pending vector.
module pulse_rr_pick
    import pulse_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    win,
    output logic             valid
);

    logic [IW-1:0] idx;

    // Scan from the slot after the previous winner and keep the first hit
    always_comb begin
        win   = last;
        valid = 1'b0;
        idx   = last;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(last) + k) % N_REQ);
            if (!valid && pend[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/pulse_arbiter.sv
// Shares one pulse output among N_REQ edge-triggered requesters,
// serving them round-robin with a programmable width and guard gap.
module pulse_arbiter
    import pulse_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [CW-1:0]    width,
    input  logic [CW-1:0]    gap,
    output logic             pulse,
    output logic [N_REQ-1:0] grant,
    output logic             done,
    output logic [N_REQ-1:0] pending,
    output logic             busy
);

    localparam int            IW       = $clog2(N_REQ);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
    localparam logic [CW-1:0] W_MIN    = CW'(WIDTH_MIN);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    w_lat;
    logic [CW-1:0]    w_lat_n;
    logic [CW-1:0]    g_lat;
    logic [CW-1:0]    g_lat_n;
    logic [N_REQ-1:0] prev_req;
    logic [N_REQ-1:0] edge_v;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] pending_n;
    logic [N_REQ-1:0] grant_n;
    logic [IW-1:0]    last;
    logic [IW-1:0]    last_n;
    logic [IW-1:0]    win;
    logic             win_vld;
    logic             take;
    logic             pulse_end;
    logic             pulse_n;
    logic             done_n;

    pulse_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .pend  (pending),
        .last  (last),
        .win   (win),
        .valid (win_vld)
    );

    // A held-high request at reset release is an edge (prev_req is 0)
    assign edge_v    = req & ~prev_req;
    assign take      = (state == IDLE) && win_vld;
    assign pulse_end = (state == PULSE) && !(cnt < w_lat);
    assign clr       = take ? (N_REQ'(1) << win) : '0;
    // Set wins over the grant clear so a same-cycle edge is kept
    assign pending_n = (pending & ~clr) | edge_v;
    assign last_n    = take ? win : last;
    assign busy      = (state != IDLE);

    // State register plus latched width/gap, counter and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            w_lat    <= W_MIN;
            g_lat    <= '0;
            prev_req <= '0;
            pending  <= '0;
            last     <= LAST_RST;
            pulse    <= 1'b0;
            grant    <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            w_lat    <= w_lat_n;
            g_lat    <= g_lat_n;
            prev_req <= req;
            pending  <= pending_n;
            last     <= last_n;
            pulse    <= pulse_n;
            grant    <= grant_n;
            done     <= done_n;
        end
    end

    // Next state and counter; width/gap are frozen at grant time
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        w_lat_n = w_lat;
        g_lat_n = g_lat;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_n = PULSE;
                    cnt_n   = ONE;
                    w_lat_n = (width < W_MIN) ? W_MIN : width;
                    g_lat_n = gap;
                end
            end
            PULSE: begin
                if (cnt < w_lat) begin
                    cnt_n = cnt + ONE;
                end else if (g_lat != '0) begin
                    state_n = GAP;
                    cnt_n   = ONE;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (cnt < g_lat) begin
                    cnt_n = cnt + ONE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next registered pulse, grant and done-strobe values
    always_comb begin
        pulse_n = pulse;
        grant_n = grant;
        done_n  = 1'b0;
        unique case (1'b1)
            take: begin
                pulse_n = 1'b1;
                grant_n = clr;
            end
            pulse_end: begin
                pulse_n = 1'b0;
                grant_n = '0;
                done_n  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed bench for pulse_arbiter with a time-since-grant model
// checked every cycle plus literal expectations per scenario.
module tb_pulse_arbiter;

    localparam int N  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [CW-1:0] width = '0;
    logic [CW-1:0] gap = '0;
    logic          pulse;
    logic [N-1:0]  grant;
    logic          done;
    logic [N-1:0]  pending;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    pulse_arbiter #(
        .N_REQ (N),
        .CW    (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .width   (width),
        .gap     (gap),
        .pulse   (pulse),
        .grant   (grant),
        .done    (done),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h want %h",
                     nm, $time, act, exp);
        end
    endtask

    // Model: pending set, rr pointer, and cycles since last grant
    logic [N-1:0] m_pend;
    logic [N-1:0] m_prev;
    logic [N-1:0] m_edge;
    logic [N-1:0] m_clr;
    int  m_last, m_owner, m_w, m_g, m_t, m_base;
    bit  m_act;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = '0;
            m_prev = '0;
            m_last = N - 1;
            m_act  = 0;
            m_t    = 0;
            m_w    = 1;
            m_g    = 0;
            m_owner = 0;
        end else begin
            m_edge = req & ~m_prev;
            m_prev = req;
            m_clr  = '0;
            if (m_act && m_t < m_w + m_g) begin
                m_t++;
            end else begin
                m_act  = 0;
                m_base = m_last;
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_base + k) % N;
                    if (!m_act && m_pend[i]) begin
                        m_act    = 1;
                        m_owner  = i;
                        m_last   = i;
                        m_w      = (width == 0) ? 1 : int'(width);
                        m_g      = int'(gap);
                        m_t      = 0;
                        m_clr[i] = 1'b1;
                    end
                end
            end
            m_pend = (m_pend & ~m_clr) | m_edge;
        end
    end

    logic         e_pulse;
    logic [N-1:0] e_grant;
    logic         e_done;
    logic         e_busy;

    always_comb begin
        e_pulse = m_act && (m_t < m_w);
        e_grant = e_pulse ? N'(1 << m_owner) : '0;
        e_done  = m_act && (m_t == m_w);
        e_busy  = m_act && (m_t < m_w + m_g);
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("m_pulse", 32'(pulse), 32'(e_pulse));
        check("m_grant", 32'(grant), 32'(e_grant));
        check("m_done", 32'(done), 32'(e_done));
        check("m_pending", 32'(pending), 32'(m_pend));
        check("m_busy", 32'(busy), 32'(e_busy));
    end

    int   g2_rises = 0;
    logic g2_prev = 1'b0;

    always @(negedge clk) begin
        if (grant[2] && !g2_prev) g2_rises++;
        g2_prev = grant[2];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        // Reset state
        width = 16'd3;
        gap   = 16'd2;
        tick(2);
        check("rst_pulse", 32'(pulse), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        reset_n = 1'b1;
        tick(2);

        // Single request, width 3 gap 2
        req = 4'b0010;
        tick(1);
        check("s_pend", 32'(pending), 32'h2);
        check("s_pulse0", 32'(pulse), 0);
        tick(1);
        check("s_pulse1", 32'(pulse), 1);
        check("s_grant", 32'(grant), 32'h2);
        check("s_busy1", 32'(busy), 1);
        req = '0;
        tick(2);
        check("s_pulse3", 32'(pulse), 1);
        tick(1);
        check("s_fall", 32'(pulse), 0);
        check("s_done", 32'(done), 1);
        check("s_busy_gap", 32'(busy), 1);
        tick(1);
        check("s_done_off", 32'(done), 0);
        check("s_busy_gap2", 32'(busy), 1);
        tick(1);
        check("s_idle", 32'(busy), 0);
        tick(3);

        // Width zero behaves as one
        width = 16'd0;
        gap   = 16'd0;
        req   = 4'b0001;
        tick(2);
        check("w0_pulse", 32'(pulse), 1);
        req = '0;
        tick(1);
        check("w0_fall", 32'(pulse), 0);
        check("w0_done", 32'(done), 1);
        tick(3);

        // Round-robin order 0,2,3 then 3 before 0
        do_reset();
        width = 16'd2;
        gap   = 16'd0;
        req   = 4'b1101;
        tick(1);
        check("rr_pend", 32'(pending), 32'hd);
        tick(1);
        check("rr_g0", 32'(grant), 32'h1);
        req = '0;
        tick(2);
        check("rr_low", 32'(pulse), 0);
        check("rr_done", 32'(done), 1);
        tick(1);
        check("rr_g2", 32'(grant), 32'h4);
        req = 4'b0001;
        tick(3);
        check("rr_g3", 32'(grant), 32'h8);
        req = '0;
        tick(3);
        check("rr_g0b", 32'(grant), 32'h1);
        tick(4);

        // Merge: two edges on req[2] while pending give one pulse
        do_reset();
        width    = 16'd4;
        gap      = 16'd1;
        g2_rises = 0;
        req      = 4'b0001;
        tick(2);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(1);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(1);
        check("mg_pend", 32'(pending), 32'h4);
        tick(12);
        check("mg_count", 32'(g2_rises), 1);
        check("mg_clear", 32'(pending), 0);
        check("mg_idle", 32'(busy), 0);

        // Set wins: edge on req[2] at its own grant edge
        g2_rises = 0;
        req      = 4'b0001;
        tick(2);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(4);
        req = 4'b0100;
        tick(1);
        check("sw_grant", 32'(grant), 32'h4);
        check("sw_pend", 32'(pending), 32'h4);
        req = '0;
        tick(5);
        check("sw_low", 32'(pulse), 0);
        check("sw_arb", 32'(busy), 0);
        tick(1);
        check("sw_again", 32'(grant), 32'h4);
        tick(8);
        check("sw_count", 32'(g2_rises), 2);

        // Width change mid-pulse affects only the next grant
        do_reset();
        width = 16'd5;
        gap   = 16'd0;
        req   = 4'b0010;
        tick(3);
        width = 16'd1;
        req   = 4'b1010;
        tick(3);
        check("wc_still", 32'(pulse), 1);
        check("wc_own", 32'(grant), 32'h2);
        tick(1);
        check("wc_fall", 32'(pulse), 0);
        check("wc_done", 32'(done), 1);
        tick(1);
        check("wc_next", 32'(grant), 32'h8);
        tick(1);
        check("wc_short", 32'(pulse), 0);
        check("wc_done2", 32'(done), 1);
        req = '0;
        tick(3);

        // Asynchronous reset in the middle of a pulse
        do_reset();
        width = 16'd4;
        gap   = 16'd0;
        req   = 4'b0110;
        tick(3);
        check("ar_pre", 32'(pulse), 1);
        check("ar_pend", 32'(pending), 32'h4);
        reset_n = 1'b0;
        #1;
        check("ar_pulse", 32'(pulse), 0);
        check("ar_grant", 32'(grant), 0);
        check("ar_pend0", 32'(pending), 0);
        check("ar_busy", 32'(busy), 0);
        req = '0;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("ar_quiet", 32'(pulse), 0);
        check("ar_qpend", 32'(pending), 0);
        reset_n = 1'b0;
        req     = 4'b0010;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("ar_e1", 32'(pulse), 0);
        check("ar_e1p", 32'(pending), 32'h2);
        tick(1);
        check("ar_e2", 32'(pulse), 1);
        check("ar_e2g", 32'(grant), 32'h2);
        tick(6);
        req = '0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_arbiter.md
# pulse_arbiter

Shares a single pulse output among N requesters. Each requester raises a level trigger. The block captures the rising edge as a pending request, then serves pending requests round-robin. Each grant produces one pulse of programmable width, followed by a programmable guard gap. It sits between the trigger sources (buttons, timers, CPU strobes) and the shared pulse-driven resource.

## Interface
- N_REQ, default 4: number of requesters, 2..8
- CW, default 16: width of the pulse-width and gap counters
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester level trigger; only rising edges matter
- width  in  CW  pulse length in cycles; sampled at grant; 0 is treated as 1
- gap  in  CW  low cycles after each pulse before the next grant; sampled at grant
- pulse  out  1  shared pulse output, registered
- grant  out  N_REQ  one-hot owner of the current pulse; high exactly while pulse=1
- done  out  1  one-cycle strobe on the cycle pulse falls
- pending  out  N_REQ  registered pending-request vector
- busy  out  1  high in PULSE and GAP

## Operation
- Edge detect:
  - A prev_req register (reset 0) is captured every cycle.
  - Edge[i] = req[i] & ~prev_req[i].
  - A request held high at reset release counts as an edge on the first clock.
- Pending:
  - Edge[i] sets pending[i]. A grant to i clears it.
  - If the edge and the clear coincide for the same channel, set wins, so the new request is kept.
  - An edge on a channel that is already pending is merged; no count is kept.
- Round-robin:
  - Pointer last holds the index of the most recent grant. Reset value is N_REQ-1, so channel 0 wins first.
  - The search order is last+1, last+2, … modulo N_REQ.
  - last updates only on a grant.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: if pending≠0, grant the winner:
    - latch W = max(width,1) and G = gap
    - set pulse=1 and grant=onehot(winner)
    - clear pending[winner], load cnt=1, go to PULSE
  - PULSE:
    - If cnt<W, increment cnt.
    - Otherwise drop pulse and grant, strobe done, and go to GAP with cnt=1 if G>0, else go to IDLE.
  - GAP: if cnt<G, increment cnt; otherwise go to IDLE.
- Counter arithmetic is unsigned CW-bit. cnt never exceeds W or G, so there is no wrap.
- Changes to width or gap during PULSE or GAP do not affect the current pulse.
- Reset, including mid-pulse:
  - pulse, grant, done, busy and pending go to 0 immediately (asynchronous).
  - State goes to IDLE, last to N_REQ-1, prev_req to 0.

## Timing
- Latency: req first sampled high at edge k → pending set at k → pulse and grant high after edge k+1, if the block is IDLE.
- Pulse is high for exactly W cycles.
- done is high for the single cycle after the last pulse cycle.
- Between consecutive pulses pulse is low for exactly G+1 cycles: G gap cycles plus one IDLE arbitration cycle.
- busy = (state≠IDLE). It is low during the arbitration cycle.
- A request arriving during PULSE or GAP waits. Worst-case wait is (N_REQ-1)·(Wmax+Gmax+1) cycles plus its own arbitration cycle.

## Structure
- Shared package pulse_pkg:
  - state enum {IDLE, PULSE, GAP}
  - default CW and N_REQ localparams
  - WIDTH_MIN = 1 constant
- Sub-module pulse_rr_pick: combinational round-robin picker.
  - Inputs: pending vector and last index.
  - Outputs: winner index and a valid flag.
  - Reused by future arbiters.
- Edge detect, pending register, FSM and counter live in the top module.

## Test plan
- Single request: width=3, gap=2, rising edge on req[1] at cycle 10 → pending[1] high after cycle 10; pulse and grant=0010 during cycles 12–14; done at 15; busy low again at 17.
- Width zero: width=0, one request on req[0] → pulse high for exactly 1 cycle, done on the next cycle.
- Round-robin: edges on req[0], req[2], req[3] in the same cycle, width=2, gap=0 → grants in order 0, 2, 3. Each pulse is 2 cycles with 1 low cycle between. Then an edge on req[0] with req[3] pending in the next round → 3 is served before 0.
- Merge and set-wins: req[2] toggled twice while pending → only one pulse. req[2] edge in the same cycle it is granted → a second pulse follows after gap+1 low cycles.
- Mid-operation change: width changed from 5 to 1 during a pulse → the current pulse stays 5 cycles and the next pulse is 1 cycle.
- Reset mid-pulse: reset_n low in cycle 2 of a 4-cycle pulse → pulse, grant, pending and busy are 0 without waiting for a clock. After release with req low, there is no pulse. After release with req[1] held high, pulse appears 2 cycles after the first clock.
